rf_read_arbiter: RTL and testbench

RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

---
 rtl/rf_read_arbiter_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/rf_read_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_read_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_read_arbiter_pkg.sv
// Shared constants for the register-file read arbiter.
// ROB tag width, owner encoding and FSM states.
package rf_read_arbiter_pkg;

  localparam int ROB_INDEX_BIT = 4;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant stage.
// The requester not granted last wins a tie.
module rr_arb2
  import rf_read_arbiter_pkg::*;
(
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

  logic a_pref;

  assign a_pref  = (last_grant == OWNER_B);
  assign grant_a = en && a_valid && (!b_valid || a_pref);
  assign grant_b = en && b_valid && (!a_valid || !a_pref);

endmodule

// File: rtl/rf_read_arbiter.sv
// Two-requester register-file read arbiter with one-cycle RF read.
// Optional commit bypass at capture: define RF_ARB_BYPASS_EN.
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int ROB_W = ROB_INDEX_BIT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             a_valid,
  input  logic [4:0]       a_rs1,
  input  logic [4:0]       a_rs2,
  input  logic             b_valid,
  input  logic [4:0]       b_rs1,
  input  logic [4:0]       b_rs2,
  output logic             a_ready,
  output logic             b_ready,
  output logic [4:0]       rf_id1,
  output logic [4:0]       rf_id2,
  input  logic [31:0]      rf_val1,
  input  logic [31:0]      rf_val2,
  input  logic [ROB_W-1:0] rf_dep1,
  input  logic [ROB_W-1:0] rf_dep2,
  input  logic             rf_has_dep1,
  input  logic             rf_has_dep2,
  input  logic [4:0]       cm_id,
  input  logic [31:0]      cm_val,
  input  logic [ROB_W-1:0] cm_rob,
  output logic             resp_valid,
  output logic             resp_owner,
  output logic [31:0]      resp_val1,
  output logic [31:0]      resp_val2,
  output logic [ROB_W-1:0] resp_dep1,
  output logic [ROB_W-1:0] resp_dep2,
  output logic             resp_has_dep1,
  output logic             resp_has_dep2
);

  localparam int OP_W = 1 + ROB_W + 32;

  arb_state_t state;
  logic       last_grant;
  logic       owner_q;
  logic [4:0] id1_q;
  logic [4:0] id2_q;

  logic arb_en;
  logic grant_a;
  logic grant_b;
  logic hs;

  logic [OP_W-1:0] op1;
  logic [OP_W-1:0] op2;

  assign arb_en = !rst_in && rdy_in && !clear &&
                  (state == S_IDLE);

  rr_arb2 u_arb (
    .en         (arb_en),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign hs      = grant_a || grant_b;
  assign rf_id1  = id1_q;
  assign rf_id2  = id2_q;

  // Packed {has_dep, dep, val}; x0 always reads as a ready zero.
  function automatic logic [OP_W-1:0] resolve(
    input logic [4:0]       id,
    input logic [31:0]      val,
    input logic [ROB_W-1:0] dep,
    input logic             has_dep
  );
    logic [OP_W-1:0] r;
    r = {has_dep, dep, val};
    if (id == 5'd0) begin
      r = '0;
    end
`ifdef RF_ARB_BYPASS_EN
    else if (cm_id == id && has_dep && dep == cm_rob) begin
      r = {1'b0, {ROB_W{1'b0}}, cm_val};
    end
`endif
    return r;
  endfunction

`ifndef RF_ARB_BYPASS_EN
  logic unused_cm;
  assign unused_cm = ^{cm_id, cm_val, cm_rob};
`endif

  assign op1 = resolve(id1_q, rf_val1, rf_dep1, rf_has_dep1);
  assign op2 = resolve(id2_q, rf_val2, rf_dep2, rf_has_dep2);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      last_grant    <= OWNER_B;
      owner_q       <= OWNER_A;
      id1_q         <= '0;
      id2_q         <= '0;
      resp_valid    <= 1'b0;
      resp_owner    <= 1'b0;
      resp_val1     <= '0;
      resp_val2     <= '0;
      resp_dep1     <= '0;
      resp_dep2     <= '0;
      resp_has_dep1 <= 1'b0;
      resp_has_dep2 <= 1'b0;
    end else if (rdy_in) begin
      resp_valid <= 1'b0;
      if (clear) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (hs) begin
              state      <= S_READ;
              last_grant <= grant_b ? OWNER_B : OWNER_A;
              owner_q    <= grant_b ? OWNER_B : OWNER_A;
              id1_q      <= grant_b ? b_rs1 : a_rs1;
              id2_q      <= grant_b ? b_rs2 : a_rs2;
            end
          end
          S_READ: begin
            state <= S_IDLE;
            resp_valid <= 1'b1;
            resp_owner <= owner_q;
            {resp_has_dep1, resp_dep1, resp_val1} <= op1;
            {resp_has_dep2, resp_dep2, resp_val2} <= op2;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed self-checking bench for rf_read_arbiter.
// Behavioural RF model; expectations are hand-computed constants.
module tb_rf_read_arbiter;
  import rf_read_arbiter_pkg::*;

  localparam int RW = ROB_INDEX_BIT;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear;
  logic          a_valid, b_valid;
  logic [4:0]    a_rs1, a_rs2, b_rs1, b_rs2;
  logic          a_ready, b_ready;
  logic [4:0]    rf_id1, rf_id2;
  logic [31:0]   rf_val1, rf_val2;
  logic [RW-1:0] rf_dep1, rf_dep2;
  logic          rf_has_dep1, rf_has_dep2;
  logic [4:0]    cm_id;
  logic [31:0]   cm_val;
  logic [RW-1:0] cm_rob;
  logic          resp_valid, resp_owner;
  logic [31:0]   resp_val1, resp_val2;
  logic [RW-1:0] resp_dep1, resp_dep2;
  logic          resp_has_dep1, resp_has_dep2;

  logic [31:0]   mem_val [32];
  logic [RW-1:0] mem_dep [32];
  logic          mem_hd  [32];

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  always_comb begin
    rf_val1     = mem_val[rf_id1];
    rf_val2     = mem_val[rf_id2];
    rf_dep1     = mem_dep[rf_id1];
    rf_dep2     = mem_dep[rf_id2];
    rf_has_dep1 = mem_hd[rf_id1];
    rf_has_dep2 = mem_hd[rf_id2];
  end

  rf_read_arbiter #(.ROB_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear(clear),
    .a_valid(a_valid), .a_rs1(a_rs1), .a_rs2(a_rs2),
    .b_valid(b_valid), .b_rs1(b_rs1), .b_rs2(b_rs2),
    .a_ready(a_ready), .b_ready(b_ready),
    .rf_id1(rf_id1), .rf_id2(rf_id2),
    .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rf_dep1(rf_dep1), .rf_dep2(rf_dep2),
    .rf_has_dep1(rf_has_dep1), .rf_has_dep2(rf_has_dep2),
    .cm_id(cm_id), .cm_val(cm_val), .cm_rob(cm_rob),
    .resp_valid(resp_valid), .resp_owner(resp_owner),
    .resp_val1(resp_val1), .resp_val2(resp_val2),
    .resp_dep1(resp_dep1), .resp_dep2(resp_dep2),
    .resp_has_dep1(resp_has_dep1),
    .resp_has_dep2(resp_has_dep2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  int n_resp;
  logic owners [4];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_val[i] = 32'h100 + i;
      mem_dep[i] = '0;
      mem_hd[i]  = 1'b0;
    end
    mem_val[5] = 32'h11;
    mem_val[6] = 32'h22;
    mem_val[0] = 32'h99;
    mem_dep[0] = 4'd3;
    mem_hd[0]  = 1'b1;
    mem_val[7] = 32'h77;
    mem_dep[7] = 4'd4;
    mem_hd[7]  = 1'b1;
    mem_val[8] = 32'h88;
    mem_dep[8] = 4'd5;
    mem_hd[8]  = 1'b1;

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_rs1 = 5'd5; a_rs2 = 5'd6; b_rs1 = 5'd1; b_rs2 = 5'd2;
    cm_id = '0; cm_val = '0; cm_rob = '0;
    tick();
    #1;
    chk("rst_a_ready", {31'b0, a_ready}, 0);
    chk("rst_b_ready", {31'b0, b_ready}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_rf_id1", {27'b0, rf_id1}, 0);
    chk("rst_resp_val1", resp_val1, 0);
    tick();
    rst_in = 1'b0; b_valid = 1'b0;

    // single request from A
    #1;
    chk("single_a_ready", {31'b0, a_ready}, 1);
    chk("single_b_ready", {31'b0, b_ready}, 0);
    tick();
    a_valid = 1'b0;
    #1;
    chk("single_read_ready", {31'b0, a_ready}, 0);
    chk("single_rf_id1", {27'b0, rf_id1}, 5);
    chk("single_rf_id2", {27'b0, rf_id2}, 6);
    chk("single_early_valid", {31'b0, resp_valid}, 0);
    tick();
    chk("single_valid", {31'b0, resp_valid}, 1);
    chk("single_owner", {31'b0, resp_owner}, 0);
    chk("single_val1", resp_val1, 32'h11);
    chk("single_val2", resp_val2, 32'h22);
    chk("single_hd1", {31'b0, resp_has_dep1}, 0);
    tick();
    chk("single_pulse", {31'b0, resp_valid}, 0);

    // tie with round-robin from fresh reset
    do_reset();
    n_resp = 0;
    a_rs1 = 5'd5; a_rs2 = 5'd6; b_rs1 = 5'd6; b_rs2 = 5'd5;
    for (int i = 0; i < 10; i++) begin
      a_valid = (i < 6);
      b_valid = (i < 6);
      #1;
      chk($sformatf("tie_a_ready_%0d", i), {31'b0, a_ready},
          {31'b0, (i < 6) && (i % 4 == 0)});
      chk($sformatf("tie_b_ready_%0d", i), {31'b0, b_ready},
          {31'b0, (i < 6) && (i % 4 == 2)});
      if (resp_valid) begin
        if (n_resp < 4) owners[n_resp] = resp_owner;
        n_resp++;
      end
      tick();
    end
    chk("tie_count", n_resp, 3);
    chk("tie_owner0", {31'b0, owners[0]}, 0);
    chk("tie_owner1", {31'b0, owners[1]}, 1);
    chk("tie_owner2", {31'b0, owners[2]}, 0);

    // x0 reads as zero without dependency
    do_reset();
    a_valid = 1'b1; a_rs1 = 5'd0; a_rs2 = 5'd5;
    tick();
    a_valid = 1'b0;
    tick();
    chk("x0_valid", {31'b0, resp_valid}, 1);
    chk("x0_val1", resp_val1, 0);
    chk("x0_hd1", {31'b0, resp_has_dep1}, 0);
    chk("x0_val2", resp_val2, 32'h11);

    // commit at capture edge
    a_valid = 1'b1; a_rs1 = 5'd7; a_rs2 = 5'd8;
    tick();
    a_valid = 1'b0;
    cm_id = 5'd7; cm_rob = 4'd4; cm_val = 32'hABCD;
    tick();
    cm_id = '0; cm_rob = '0; cm_val = '0;
    chk("byp_valid", {31'b0, resp_valid}, 1);
`ifdef RF_ARB_BYPASS_EN
    chk("byp_val1", resp_val1, 32'hABCD);
    chk("byp_hd1", {31'b0, resp_has_dep1}, 0);
`else
    chk("byp_val1", resp_val1, 32'h77);
    chk("byp_hd1", {31'b0, resp_has_dep1}, 1);
    chk("byp_dep1", {28'b0, resp_dep1}, 4);
`endif
    chk("byp_hd2", {31'b0, resp_has_dep2}, 1);
    chk("byp_dep2", {28'b0, resp_dep2}, 5);
    chk("byp_val2", resp_val2, 32'h88);

    // flush during READ
    b_valid = 1'b1; b_rs1 = 5'd5; b_rs2 = 5'd6;
    #1;
    chk("flush_b_ready", {31'b0, b_ready}, 1);
    tick();
    b_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("flush_ready_in_clear", {31'b0, b_ready}, 0);
    tick();
    clear = 1'b0;
    chk("flush_no_resp", {31'b0, resp_valid}, 0);
    a_valid = 1'b1; a_rs1 = 5'd6; a_rs2 = 5'd5;
    #1;
    chk("flush_idle_ready", {31'b0, a_ready}, 1);
    tick();
    a_valid = 1'b0;
    chk("flush_still_none", {31'b0, resp_valid}, 0);
    tick();
    chk("flush_next_valid", {31'b0, resp_valid}, 1);
    chk("flush_next_owner", {31'b0, resp_owner}, 0);
    chk("flush_next_val1", resp_val1, 32'h22);

    // pause three cycles in READ
    b_valid = 1'b1; b_rs1 = 5'd5; b_rs2 = 5'd6;
    tick();
    b_valid = 1'b0;
    rdy_in = 1'b0;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("pause_ready_%0d", i), {31'b0, a_ready}, 0);
      tick();
      chk($sformatf("pause_valid_%0d", i),
          {31'b0, resp_valid}, 0);
    end
    a_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("pause_valid", {31'b0, resp_valid}, 1);
    chk("pause_owner", {31'b0, resp_owner}, 1);
    chk("pause_val1", resp_val1, 32'h11);
    chk("pause_val2", resp_val2, 32'h22);
    tick();
    chk("pause_pulse", {31'b0, resp_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
